// File: rtl/wmem_pkg.sv
// Shared definitions for the weight-memory loader: FSM states and address-width helper.
package wmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_N_IN     = 128;
  localparam int DEF_N_HIDDEN = 64;
  localparam int CHECKSUM_W   = 32;

  // Index width for a range of n entries; at least one bit even for n < 2.
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wmem_loader.sv
// Streams weight words into a (hidden, input)-indexed memory, one write per accepted beat.
// Optional WMEM_LOADER_CHECKSUM_EN adds a 32-bit running sum of the written words.
module wmem_loader
  import wmem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int N_IN     = DEF_N_IN,
  parameter int N_HIDDEN = DEF_N_HIDDEN,
  localparam int HW      = addr_w(N_HIDDEN),
  localparam int IW      = addr_w(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     w_wr_en,
  output logic [HW-1:0]            w_addr_h,
  output logic [IW-1:0]            w_addr_i,
  output logic signed [DATA_W-1:0] w_data,
`ifdef WMEM_LOADER_CHECKSUM_EN
  output logic [CHECKSUM_W-1:0]    checksum,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  state_e                   state_q, state_d;
  logic [HW-1:0]            h_q, h_d;
  logic [IW-1:0]            i_q, i_d;
  logic                     err_q, err_d;
  logic                     wr_q, wr_d;
  logic [HW-1:0]            addr_h_q, addr_h_d;
  logic [IW-1:0]            addr_i_q, addr_i_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic                     accept;
  logic                     final_pos;

`ifdef WMEM_LOADER_CHECKSUM_EN
  logic [CHECKSUM_W-1:0]    sum_q, sum_d;
`endif

  assign accept    = (state_q == LOAD) && s_valid;
  assign final_pos = (h_q == HW'(N_HIDDEN - 1)) && (i_q == IW'(N_IN - 1));

  // Abort outranks everything in LOAD, including a beat that would end the pass.
  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    i_d      = i_q;
    err_d    = err_q;
    wr_d     = 1'b0;
    addr_h_d = addr_h_q;
    addr_i_d = addr_i_q;
    data_d   = data_q;
`ifdef WMEM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          h_d     = '0;
          i_d     = '0;
          err_d   = 1'b0;
`ifdef WMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          wr_d     = 1'b1;
          addr_h_d = h_q;
          addr_i_d = i_q;
          data_d   = s_data;
`ifdef WMEM_LOADER_CHECKSUM_EN
          sum_d    = sum_q + CHECKSUM_W'(s_data);
`endif
          if (s_last || final_pos) begin
            state_d = DONE;
            err_d   = (s_last != final_pos);
          end else if (i_q == IW'(N_IN - 1)) begin
            i_d = '0;
            h_d = h_q + HW'(1);
          end else begin
            i_d = i_q + IW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      h_q      <= '0;
      i_q      <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_h_q <= '0;
      addr_i_q <= '0;
      data_q   <= '0;
`ifdef WMEM_LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      i_q      <= i_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      addr_h_q <= addr_h_d;
      addr_i_q <= addr_i_d;
      data_q   <= data_d;
`ifdef WMEM_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign s_ready  = (state_q == LOAD);
  assign busy     = (state_q == LOAD);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign w_wr_en  = wr_q;
  assign w_addr_h = addr_h_q;
  assign w_addr_i = addr_i_q;
  assign w_data   = data_q;
`ifdef WMEM_LOADER_CHECKSUM_EN
  assign checksum = sum_q;
`endif

endmodule
